// File: rtl/hsv_encoder_pkg.sv
// Shared encodings for the HSV quadrature encoder: resolution modes,
// quadrature states ({a,b}) and the transition decoder.
package hsv_encoder_pkg;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    // Forward rotation walks Q00 -> Q10 -> Q11 -> Q01 -> Q00.
    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    typedef struct packed {
        logic up;
        logic dn;
        logic bad;
    } qdec_t;

    // Classify one {a,b} transition under the selected resolution.
    function automatic qdec_t quad_decode(input logic [1:0] m,
                                          input logic [1:0] p,
                                          input logic [1:0] c);
        qdec_t r;
        logic  fwd;
        logic  counts;
        r      = '0;
        fwd    = 1'b0;
        counts = 1'b0;
        if ((p ^ c) == 2'b11) begin
            r.bad = 1'b1;
        end else if (p != c) begin
            fwd = ((p == Q00) && (c == Q10)) || ((p == Q10) && (c == Q11)) ||
                  ((p == Q11) && (c == Q01)) || ((p == Q01) && (c == Q00));
            // x1 counts only transitions leaving 00, x2 those leaving 00 or 11.
            case (m)
                MODE_X1: counts = (p == Q00);
                MODE_X2: counts = (p == Q00) || (p == Q11);
                MODE_X4: counts = 1'b1;
                default: counts = 1'b1;
            endcase
            r.up = counts & fwd;
            r.dn = counts & ~fwd;
        end
        return r;
    endfunction

endpackage

// File: rtl/hsv_enc_filter.sv
// One encoder pin: 2-FF synchroniser, persistence filter and the
// post-reset arm window that seeds the filtered state from the pin.
module hsv_enc_filter #(
    parameter int unsigned FILTER = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt,
    output logic filt_prev,
    output logic arming
);

    localparam logic [7:0] FILT_LIM = 8'(FILTER);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;
    logic [1:0] arm_cnt;

    assign arming = (arm_cnt != 2'd3);

    // Synchronise, then accept a new level only after it persists FILTER extra cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            filt      <= 1'b0;
            filt_prev <= 1'b0;
            cnt       <= '0;
            arm_cnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (arming) begin
                arm_cnt   <= arm_cnt + 2'd1;
                // prev tracks filt here too so the first decode sees no edge
                filt      <= sync2;
                filt_prev <= sync2;
                cnt       <= '0;
            end else begin
                filt_prev <= filt;
                if (sync2 != filt) begin
                    if (cnt == FILT_LIM) begin
                        filt <= sync2;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/hsv_quad_encoder.sv
// Quadrature encoder counter for one HSV channel: filtered pins, x1/x2/x4
// decode, stepped counting with wrap/saturate limits, preload and error flag.
module hsv_quad_encoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned FILTER    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       mode,
    input  logic             sat,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             err_clr,
    output logic [WIDTH-1:0] value,
    output logic             dir,
    output logic             step_pulse,
    output logic             err
);

    import hsv_encoder_pkg::*;

    localparam logic [WIDTH:0]   MIN_E   = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_E   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_E  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic             filt_a, filt_b, prev_a, prev_b;
    logic             arming_a, arming_b, arming;
    qdec_t            dec;
    logic             count_ev, bad_ev;
    logic [WIDTH:0]   val_e, up_sum, ld_e;
    logic [WIDTH-1:0] next_up, next_dn, ld_clamped;

    hsv_enc_filter #(.FILTER(FILTER)) u_filt_a (
        .clk       (clk),
        .reset     (reset),
        .pin       (a),
        .filt      (filt_a),
        .filt_prev (prev_a),
        .arming    (arming_a)
    );

    hsv_enc_filter #(.FILTER(FILTER)) u_filt_b (
        .clk       (clk),
        .reset     (reset),
        .pin       (b),
        .filt      (filt_b),
        .filt_prev (prev_b),
        .arming    (arming_b)
    );

    assign arming = arming_a | arming_b;

    // Decode the filtered transition and precompute limited next values.
    always_comb begin
        dec        = quad_decode(mode, {prev_a, prev_b}, {filt_a, filt_b});
        count_ev   = ~arming & (dec.up | dec.dn);
        bad_ev     = ~arming & dec.bad;
        val_e      = {1'b0, value};
        up_sum     = val_e + STEP_E;
        ld_e       = {1'b0, load_value};
        next_up    = value + STEP_W;
        next_dn    = value - STEP_W;
        if (up_sum > MAX_E) begin
            next_up = sat ? MAX_W : MIN_W;
        end
        if (val_e < MIN_E + STEP_E) begin
            next_dn = sat ? MIN_W : MAX_W;
        end
        ld_clamped = load_value;
        if (ld_e < MIN_E) begin
            ld_clamped = MIN_W;
        end else if (ld_e > MAX_E) begin
            ld_clamped = MAX_W;
        end
    end

    // Output registers: load beats a count; err is sticky and a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value      <= RESET_W;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (load) begin
                value <= ld_clamped;
            end else if (count_ev && enable) begin
                value      <= dec.up ? next_up : next_dn;
                dir        <= dec.up;
                step_pulse <= 1'b1;
            end
            if (bad_ev) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hsv_quad_encoder.sv
// Bench for hsv_quad_encoder: three parameterisations side by side,
// random quadrature walks against a phase-arithmetic model, plus tables
// and hand sequences for latency, limits, filter, errors and preload.
module tb_hsv_quad_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] a_i, b_i, load_i;
    logic [1:0] mode;
    logic       sat, enable, err_clr;
    logic [7:0] load_value;
    logic [7:0] val0, val1, val2;
    logic [2:0] dir_w, sp_w, err_w;

    always #5 clk = ~clk;

    hsv_quad_encoder u_dut0 (
        .clk(clk), .reset(reset), .a(a_i[0]), .b(b_i[0]), .mode(mode), .sat(sat),
        .enable(enable), .load(load_i[0]), .load_value(load_value), .err_clr(err_clr),
        .value(val0), .dir(dir_w[0]), .step_pulse(sp_w[0]), .err(err_w[0]));

    hsv_quad_encoder #(.WIDTH(8), .STEP(3), .MIN_VAL(0), .MAX_VAL(10), .RESET_VAL(9), .FILTER(0)) u_dut1 (
        .clk(clk), .reset(reset), .a(a_i[1]), .b(b_i[1]), .mode(mode), .sat(sat),
        .enable(enable), .load(load_i[1]), .load_value(load_value), .err_clr(err_clr),
        .value(val1), .dir(dir_w[1]), .step_pulse(sp_w[1]), .err(err_w[1]));

    hsv_quad_encoder #(.WIDTH(8), .STEP(1), .MIN_VAL(5), .MAX_VAL(150), .RESET_VAL(5), .FILTER(4)) u_dut2 (
        .clk(clk), .reset(reset), .a(a_i[2]), .b(b_i[2]), .mode(mode), .sat(sat),
        .enable(enable), .load(load_i[2]), .load_value(load_value), .err_clr(err_clr),
        .value(val2), .dir(dir_w[2]), .step_pulse(sp_w[2]), .err(err_w[2]));

    int errors = 0;
    int checks = 0;
    int pcnt[3] = '{0, 0, 0};

    int P_STEP[3] = '{1, 3, 1};
    int P_MIN[3]  = '{0, 0, 5};
    int P_MAX[3]  = '{255, 10, 150};
    int P_RST[3]  = '{0, 9, 5};

    // model state: value, dir, err, phase (0:00 1:10 2:11 3:01), pulse count
    int mv[3], md[3], me[3], mph[3], mpc[3];

    typedef struct {
        bit a;
        bit b;
        int mode;
        int val;
        int dir;
        int pulses;
    } vec_t;
    vec_t tbl[$];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) if (sp_w[i]) pcnt[i]++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int val_of(int i);
        case (i)
            0: return int'(val0);
            1: return int'(val1);
            default: return int'(val2);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_phase(int i, int ph);
        a_i[i] = (ph == 1) || (ph == 2);
        b_i[i] = (ph == 2) || (ph == 3);
    endtask

    // Reference: a transition is a phase difference mod 4 (1 fwd, 3 rev, 2 illegal).
    task automatic model(int i, int nph, int m, bit s, bit en, bit clr);
        int d;
        int old;
        bit cnt;
        bit up;
        d   = (nph - mph[i] + 4) % 4;
        old = mph[i];
        cnt = 1'b0;
        up  = (d == 1);
        if (clr) me[i] = 0;
        if (d == 2) me[i] = 1;
        else if (d != 0) begin
            case (m)
                0: cnt = (old == 0);
                1: cnt = (old % 2 == 0);
                default: cnt = 1'b1;
            endcase
        end
        if (cnt && en) begin
            if (up) mv[i] = (mv[i] + P_STEP[i] > P_MAX[i]) ? (s ? P_MAX[i] : P_MIN[i]) : mv[i] + P_STEP[i];
            else    mv[i] = (mv[i] < P_MIN[i] + P_STEP[i]) ? (s ? P_MIN[i] : P_MAX[i]) : mv[i] - P_STEP[i];
            md[i] = up;
            mpc[i]++;
        end
        mph[i] = nph;
    endtask

    task automatic add(bit a, bit b, int m, int v, int d, int p);
        vec_t r;
        r = '{a: a, b: b, mode: m, val: v, dir: d, pulses: p};
        tbl.push_back(r);
    endtask

    task automatic load_one(int i, int v);
        load_value = 8'(v);
        load_i[i]  = 1'b1;
        ticks(1);
        load_i[i]  = 1'b0;
    endtask

    initial begin
        int p0;
        // dut0 from value 0, pins 00
        add(1,0,2, 1,1,1); add(1,1,2, 2,1,1); add(0,1,2, 3,1,1); add(0,0,2, 4,1,1);
        add(0,1,2, 3,0,1); add(1,1,2, 2,0,1); add(1,0,2, 1,0,1); add(0,0,2, 0,0,1);
        add(1,0,1, 1,1,1); add(1,1,1, 1,1,0); add(0,1,1, 2,1,1); add(0,0,1, 2,1,0);
        add(1,0,0, 3,1,1); add(1,1,0, 3,1,0); add(0,1,0, 3,1,0); add(0,0,0, 3,1,0);
        add(1,0,0, 4,1,1); add(1,1,0, 4,1,0); add(0,1,0, 4,1,0); add(0,0,0, 4,1,0);
        add(1,0,0, 5,1,1); add(1,1,0, 5,1,0); add(0,1,0, 5,1,0); add(0,0,0, 5,1,0);
        add(0,1,0, 4,0,1); add(1,1,0, 4,0,0); add(1,0,0, 4,0,0); add(0,0,0, 4,0,0);

        reset = 1'b0; a_i = 3'b111; b_i = 3'b111; load_i = '0;
        mode = 2'd2; sat = 1'b0; enable = 1'b1; err_clr = 1'b0; load_value = '0;
        ticks(3);
        reset = 1'b1;
        ticks(12);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_val%0d", i), val_of(i), P_RST[i]);
            check($sformatf("reset_dir%0d", i), int'(dir_w[i]), 0);
            check($sformatf("reset_err%0d", i), int'(err_w[i]), 0);
            check($sformatf("reset_pulses%0d", i), pcnt[i], 0);
            mv[i] = P_RST[i]; md[i] = 0; me[i] = 0; mph[i] = 2; mpc[i] = 0;
        end

        // random walks, all three instances against the model
        for (int it = 0; it < 60; it++) begin
            mode    = 2'($urandom_range(0, 3));
            sat     = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 3; i++) begin
                int r, nph;
                r   = $urandom_range(0, 9);
                nph = (mph[i] + ((r == 0) ? 2 : (r < 5) ? 1 : 3)) % 4;
                set_phase(i, nph);
                model(i, nph, int'(mode), sat, enable, err_clr);
            end
            ticks(1);
            err_clr = 1'b0;
            ticks(11);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rnd%0d_val%0d", it, i), val_of(i), mv[i]);
                check($sformatf("rnd%0d_dir%0d", it, i), int'(dir_w[i]), md[i]);
                check($sformatf("rnd%0d_err%0d", it, i), int'(err_w[i]), me[i]);
                check($sformatf("rnd%0d_pulses%0d", it, i), pcnt[i], mpc[i]);
            end
        end

        // park all pins at 00 without counting, clear err, preload
        enable = 1'b0;
        for (int i = 0; i < 3; i++) set_phase(i, 0);
        ticks(12);
        err_clr = 1'b1; ticks(1); err_clr = 1'b0;
        enable = 1'b1; mode = 2'd2; sat = 1'b0;
        load_value = 8'd0; load_i = 3'b101; ticks(1); load_i = '0; ticks(1);
        check("load_dut0", int'(val0), 0);
        check("load_clamp_min", int'(val2), 5);
        check("err_cleared", int'(err_w), 0);

        // resolution table on dut0
        foreach (tbl[k]) begin
            p0 = pcnt[0];
            a_i[0] = tbl[k].a; b_i[0] = tbl[k].b; mode = 2'(tbl[k].mode);
            ticks(10);
            check($sformatf("tbl%0d_val", k), int'(val0), tbl[k].val);
            check($sformatf("tbl%0d_dir", k), int'(dir_w[0]), tbl[k].dir);
            check($sformatf("tbl%0d_pulses", k), pcnt[0] - p0, tbl[k].pulses);
        end

        // latency: first update on edge 4 after a rises
        mode = 2'd2; ticks(2);
        a_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latency_edge3", int'(val0), 4);
        @(posedge clk);
        #1 check("latency_edge4", int'(val0), 5);
        @(negedge clk);

        // illegal jumps and err_clr interplay
        a_i[0] = 1'b0; b_i[0] = 1'b1;
        ticks(10);
        check("illegal_err", int'(err_w[0]), 1);
        check("illegal_val", int'(val0), 5);
        a_i[0] = 1'b1; b_i[0] = 1'b0;
        ticks(3);
        err_clr = 1'b1; ticks(1); err_clr = 1'b0;
        check("err_clr_vs_new", int'(err_w[0]), 1);
        ticks(3);
        err_clr = 1'b1; ticks(1); err_clr = 1'b0; ticks(1);
        check("err_clr", int'(err_w[0]), 0);
        check("illegal_val2", int'(val0), 5);

        // dut1 limits: STEP=3, range 0..10
        load_one(1, 9);
        sat = 1'b1; p0 = pcnt[1];
        set_phase(1, 1); ticks(10);
        check("sat_up_val", int'(val1), 10);
        check("sat_up_pulse", pcnt[1] - p0, 1);
        p0 = pcnt[1];
        set_phase(1, 2); ticks(10);
        check("sat_hold_val", int'(val1), 10);
        check("sat_hold_pulse", pcnt[1] - p0, 1);
        sat = 1'b0;
        load_one(1, 9);
        set_phase(1, 3); ticks(10);
        check("wrap_up_val", int'(val1), 0);
        load_one(1, 1);
        set_phase(1, 2); ticks(10);
        check("wrap_dn_val", int'(val1), 10);
        check("wrap_dn_dir", int'(dir_w[1]), 0);
        sat = 1'b1;
        load_one(1, 1);
        set_phase(1, 1); ticks(10);
        check("sat_dn_val", int'(val1), 0);

        // dut2 FILTER=4: short glitch rejected, long level accepted on edge 8
        p0 = pcnt[2];
        a_i[2] = 1'b1; ticks(3); a_i[2] = 1'b0;
        ticks(15);
        check("glitch_val", int'(val2), 5);
        check("glitch_pulse", pcnt[2] - p0, 0);
        a_i[2] = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("filter_edge7", int'(val2), 5);
        @(posedge clk);
        #1 check("filter_edge8", int'(val2), 6);
        @(negedge clk);

        // preload colliding with a count: clamp to 150, count dropped
        p0 = pcnt[2];
        b_i[2] = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        load_value = 8'd200; load_i[2] = 1'b1;
        @(posedge clk);
        #1 check("load_clamp_max", int'(val2), 150);
        check("load_no_pulse", int'(sp_w[2]), 0);
        @(negedge clk);
        load_i[2] = 1'b0;
        ticks(5);
        check("load_hold_val", int'(val2), 150);
        check("load_pulses", pcnt[2] - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
